// File: rtl/accum_deskew_fifo_if.sv
// Bundle of the deskew FIFO's array-side input and consumer-side handshake.
// The block itself connects through "slave"; the producer/consumer side uses "master".
interface accum_deskew_fifo_if #(
  parameter int OC0   = 4,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                accum_valid_in;
  logic [32*OC0-1:0]   accum_in_chained;
  logic                out_valid;
  logic                out_ready;
  logic [32*OC0-1:0]   out_data;
  logic [CW-1:0]       fifo_count;
  logic                ready_for_more;
  logic                overflow;

  modport master (
    output accum_valid_in, accum_in_chained, out_ready,
    input  out_valid, out_data, fifo_count, ready_for_more, overflow
  );

  modport slave (
    input  accum_valid_in, accum_in_chained, out_ready,
    output out_valid, out_data, fifo_count, ready_for_more, overflow
  );
endinterface

// File: rtl/accum_deskew_fifo.sv
// Realigns the MAC array's column-skewed bottom-row sums into one word per vector
// and queues the words in a first-word-fall-through FIFO with credit-style flow control.
module accum_deskew_fifo #(
  parameter int IC0   = 4,
  parameter int OC0   = 4,   // must be >= 2
  parameter int DEPTH = 16   // power of 2, >= 2*(IC0+OC0)
) (
  input  logic                clk,
  input  logic                rst,
  accum_deskew_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int W  = 32 * OC0;
  localparam int SR = OC0 - 1;

  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [CW+1:0] MARGIN   = (CW+2)'(IC0);
  localparam logic [CW+1:0] DEPTH_W  = (CW+2)'(DEPTH);

  logic [SR-1:0]  vsr;
  logic           v_aligned;
  logic [W-1:0]   aligned;

  logic [W-1:0]   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           overflow_q;

  logic           empty;
  logic           full;
  logic           do_read;
  logic           do_write;
  logic           drop;
  logic [CW+1:0]  inflight;

  // ---------------------------------------------------------------- deskew
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbour; blocking here would collapse the shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      vsr <= '0;
    end else begin
      vsr[0] <= bus.accum_valid_in;
      for (int k = 1; k < SR; k++) vsr[k] <= vsr[k-1];
    end
  end

  assign v_aligned = vsr[SR-1];

  // Column j waits OC0-1-j cycles so it lines up with the last column.
  for (genvar j = 0; j < OC0 - 1; j++) begin : g_col
    localparam int N = OC0 - 1 - j;
    logic [31:0] pipe [N];

    always_ff @(posedge clk) begin
      pipe[0] <= bus.accum_in_chained[32*j +: 32];
      for (int k = 1; k < N; k++) pipe[k] <= pipe[k-1];
    end

    assign aligned[32*j +: 32] = pipe[N-1];
  end

  assign aligned[32*(OC0-1) +: 32] = bus.accum_in_chained[32*(OC0-1) +: 32];

  // ------------------------------------------------------------------ FIFO
  assign empty    = (count == '0);
  assign full     = (count == FULL);
  assign do_read  = !empty && bus.out_ready;
  // A full queue still accepts a word when the head leaves in the same cycle.
  assign do_write = v_aligned && (!full || do_read);
  assign drop     = v_aligned && full && !do_read;

  // NOTE: the storage array has no reset; only pointers and count define which
  // entries are meaningful, so clearing it would add logic without changing behaviour.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= aligned;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + AW'(1);
      if (do_read)  rd_ptr <= rd_ptr + AW'(1);
      if (do_write && !do_read)      count <= count + CW'(1);
      else if (do_read && !do_write) count <= count - CW'(1);
      if (drop) overflow_q <= 1'b1;
    end
  end

  // ------------------------------------------------------------ flow control
  // NOTE: every variable in a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    inflight = '0;
    for (int k = 0; k < SR; k++) inflight = inflight + {{(CW+1){1'b0}}, vsr[k]};
  end

  assign bus.ready_for_more = ({2'b00, count} + inflight + MARGIN) < DEPTH_W;
  assign bus.out_valid      = !empty;
  assign bus.out_data       = empty ? '0 : mem[rd_ptr];
  assign bus.fifo_count     = count;
  assign bus.overflow       = overflow_q;

endmodule
